gc_sync_decoder: RTL and testbench
==================================

GC_SYNC_DECODER -- requirements
Module: gc_sync_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, Gray/binary word width (2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-003 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Gc_input  input  WIDTH  Gray code word, asynchronous to clk, one bit changing per step.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of Err_count.
REQ-007 SHALL have port Bin_output  output  WIDTH  registered binary equivalent of the last accepted Gray word.
REQ-008 SHALL have port Bin_valid  output  1  one-cycle pulse when Bin_output updates.
REQ-009 SHALL have port Dir_up  output  1  1 = last accepted step was +1 mod 2^WIDTH; held until the next step.
REQ-010 SHALL have port Step_err  output  1  one-cycle pulse on an illegal multi-bit Gray change.
REQ-011 SHALL have port Err_count  output  4  saturating count of illegal changes.

Function
REQ-012 SHALL pass Gc_input through a SYNC_STAGES-deep flop chain; the decoder SHALL use only the chain output (gs).
REQ-013 SHALL run FSM WAIT -> LOAD -> TRACK; WAIT lasts SYNC_STAGES cycles (down-counter) after reset release.
REQ-014 In LOAD, SHALL capture gs as baseline gc_q, set Bin_output = g2b(gs), keep Bin_valid = 0, then go to TRACK.
REQ-015 In TRACK, each cycle SHALL compute d = gs XOR gc_q; d = 0 -> no output change, no pulse.
REQ-016 popcount(d) = 1 -> gc_q <= gs, Bin_output <= g2b(gs), Bin_valid = 1 for one cycle, Dir_up <= (g2b(gs) == g2b(gc_q)+1 mod 2^WIDTH).
REQ-017 popcount(d) > 1 -> value SHALL still be accepted (resync) with Bin_valid = 1; Dir_up SHALL be unchanged; error handling per REQ-024.
REQ-018 Wrap-around: binary 15->0 (Gray 1000->0000) SHALL give Dir_up = 1; 0->15 SHALL give Dir_up = 0.
REQ-019 g2b SHALL be b[W-1] = g[W-1], b[i] = b[i+1] XOR g[i]; exact inverse of the team's binary-to-Gray map.
REQ-020 Latency: a Gc_input change stable before edge k SHALL appear on Bin_output and Bin_valid after edge k+SYNC_STAGES.
REQ-021 Err_count SHALL saturate at 15; clr_err SHALL zero it; clr_err and a new error in the same cycle -> Err_count = 0, Step_err still pulses.

Reset
REQ-022 On rst_n low, SHALL immediately force: sync chain and gc_q = 0, Bin_output = 0, Bin_valid = 0, Dir_up = 0, Step_err = 0, Err_count = 0, FSM = WAIT.
REQ-023 Reset asserted mid-operation SHALL abort any step; no pulse SHALL be produced in the cycle of release; the WAIT/LOAD sequence SHALL repeat.

Configuration
REQ-024 With GC_ERR_CHECK_EN defined: Step_err and Err_count SHALL behave per REQ-017/REQ-021.
REQ-025 Without GC_ERR_CHECK_EN: Step_err and Err_count SHALL be constant 0, clr_err SHALL be ignored, and multi-bit changes SHALL be accepted as in REQ-017 with no error indication.

Structure
REQ-026 Package gc_pkg SHALL hold the g2b and b2g functions, the FSM state enum (WAIT, LOAD, TRACK), and ERR_CNT_W = 4.
REQ-027 The synchronizer chain SHALL be a separate sub-module gc_sync (parameters WIDTH, SYNC_STAGES; ports clk, rst_n, d, q).

Verification
REQ-028 Reset, hold Gc_input = 0101 -> Bin_valid stays 0, Bin_output = 0110 after SYNC_STAGES+1 edges, FSM in TRACK.
REQ-029 Step Gc_input 0000->0001->0011->0010 one change per 4 cycles -> Bin_output 1,2,3, three Bin_valid pulses, Dir_up = 1, each change appears SYNC_STAGES edges after sampling.
REQ-030 From Gray 1000 (bin 15) step to 0000, then back to 1000 -> Bin_output 0 with Dir_up = 1, then 15 with Dir_up = 0.
REQ-031 Macro on: jump Gray 0000->0011 -> Step_err pulse, Err_count = 1, Bin_output = 0010, Dir_up unchanged; 20 jumps -> Err_count = 15; clr_err together with a jump -> Err_count = 0, Step_err = 1.
REQ-032 Macro off: same 0000->0011 jump -> Bin_output = 0010, Bin_valid = 1, Step_err = 0, Err_count = 0.
REQ-033 Assert rst_n low during a step in flight -> all outputs 0 asynchronously; after release, no Bin_valid until a post-LOAD change.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared types and Gray/binary helpers for the Gray-code sync decoder.
// Helpers work on GC_MAX_W-bit words; narrower words are zero-extended, which leaves both maps unchanged.
package gc_pkg;

  localparam int ERR_CNT_W = 4;
  localparam int GC_MAX_W  = 8;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    LOAD  = 2'd1,
    TRACK = 2'd2
  } gc_state_e;

  function automatic logic [GC_MAX_W-1:0] g2b(input logic [GC_MAX_W-1:0] g);
    logic [GC_MAX_W-1:0] b;
    b[GC_MAX_W-1] = g[GC_MAX_W-1];
    for (int i = GC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GC_MAX_W-1:0] b2g(input logic [GC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gc_sync.sv
// Multi-flop synchronizer for an asynchronous Gray-code word.
module gc_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gc_sync_decoder.sv
// Synchronizes an asynchronous Gray counter, decodes it to binary and reports step direction.
// Define GC_ERR_CHECK_EN to enable multi-bit-change detection (Step_err / Err_count).
module gc_sync_decoder
  import gc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     Gc_input,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     Bin_output,
  output logic                 Bin_valid,
  output logic                 Dir_up,
  output logic                 Step_err,
  output logic [ERR_CNT_W-1:0] Err_count
);

  localparam int CNT_W = 3;

  logic [WIDTH-1:0]    gs;
  logic [GC_MAX_W-1:0] gs_ext;
  logic [WIDTH-1:0]    bin_gs;
  logic [WIDTH-1:0]    diff;
  logic                single;

  gc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gc_q, gc_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             vld_q, vld_d;
  logic             dir_q, dir_d;
`ifdef GC_ERR_CHECK_EN
  logic                 serr_q, serr_d;
  logic [ERR_CNT_W-1:0] ecnt_q, ecnt_d;
`else
  logic                 clr_err_unused;
`endif

  gc_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (Gc_input),
    .q    (gs)
  );

  always_comb begin
    gs_ext            = '0;
    gs_ext[WIDTH-1:0] = gs;
  end

  assign bin_gs = WIDTH'(g2b(gs_ext));
  assign diff   = gs ^ gc_q;
  // Exactly one bit set: non-zero and no second bit left after clearing the lowest.
  assign single = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gc_d    = gc_q;
    bin_d   = bin_q;
    vld_d   = 1'b0;
    dir_d   = dir_q;
`ifdef GC_ERR_CHECK_EN
    serr_d  = 1'b0;
    ecnt_d  = clr_err ? '0 : ecnt_q;
`endif
    case (state_q)
      WAIT: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      LOAD: begin
        gc_d    = gs;
        bin_d   = bin_gs;
        state_d = TRACK;
      end
      TRACK: begin
        if (diff != '0) begin
          gc_d  = gs;
          bin_d = bin_gs;
          vld_d = 1'b1;
          if (single) begin
            dir_d = (bin_gs == bin_q + WIDTH'(1));
          end else begin
`ifdef GC_ERR_CHECK_EN
            serr_d = 1'b1;
            if (!clr_err && ecnt_q != '1) ecnt_d = ecnt_q + ERR_CNT_W'(1);
`endif
          end
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      cnt_q   <= CNT_W'(SYNC_STAGES - 1);
      gc_q    <= '0;
      bin_q   <= '0;
      vld_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gc_q    <= gc_d;
      bin_q   <= bin_d;
      vld_q   <= vld_d;
      dir_q   <= dir_d;
    end
  end

`ifdef GC_ERR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serr_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      serr_q <= serr_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign Step_err  = serr_q;
  assign Err_count = ecnt_q;
`else
  assign clr_err_unused = clr_err;
  assign Step_err       = 1'b0;
  assign Err_count      = '0;
`endif

  assign Bin_output = bin_q;
  assign Bin_valid  = vld_q;
  assign Dir_up     = dir_q;

endmodule

// File: tb/tb_gc_sync_decoder.sv
// Scoreboard bench for gc_sync_decoder (works with or without GC_ERR_CHECK_EN).
module tb_gc_sync_decoder;
  import gc_pkg::*;

  localparam int W = 4;
  localparam int S = 2;
`ifdef GC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] Gc_input = '0;
  logic [W-1:0] Bin_output;
  logic         Bin_valid;
  logic         Dir_up;
  logic         Step_err;
  logic [3:0]   Err_count;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         dir;
    logic         serr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_gray, m_bin;
  logic         m_dir;
  int           m_ecnt;

  gc_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Gc_input  (Gc_input),
    .clr_err   (clr_err),
    .Bin_output(Bin_output),
    .Bin_valid (Bin_valid),
    .Dir_up    (Dir_up),
    .Step_err  (Step_err),
    .Err_count (Err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Scoreboard consumer: every Bin_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (Bin_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_valid got bin=%0d", Bin_output);
        end else begin
          mon_e = sb.pop_front();
          if (Bin_output !== mon_e.bin || Dir_up !== mon_e.dir || Step_err !== mon_e.serr) begin
            errors++;
            $display("FAIL sb_entry got bin=%0d dir=%b serr=%b expected bin=%0d dir=%b serr=%b",
                     Bin_output, Dir_up, Step_err, mon_e.bin, mon_e.dir, mon_e.serr);
          end
        end
      end else if (Step_err !== 1'b0) begin
        errors++;
        $display("FAIL sb_stray_step_err got %b expected 0", Step_err);
      end
    end
  end

  task automatic do_reset(input logic [W-1:0] g);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    Gc_input = g;
    clr_err  = 1'b0;
    #1;
    checks++;
    if ({Bin_output, Bin_valid, Dir_up, Step_err, Err_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bin=%0d vld=%b dir=%b serr=%b ecnt=%0d expected all 0",
               Bin_output, Bin_valid, Dir_up, Step_err, Err_count);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= S; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (Bin_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_no_valid edge=%0d got %b expected 0", i + 1, Bin_valid);
      end
      if (i < S) begin
        checks++;
        if (Bin_output !== '0) begin
          errors++;
          $display("FAIL load_early edge=%0d got bin=%0d expected 0", i + 1, Bin_output);
        end
      end
    end
    checks++;
    if (Bin_output !== ref_g2b(g)) begin
      errors++;
      $display("FAIL load_value got %0d expected %0d", Bin_output, ref_g2b(g));
    end
    checks++;
    if (dut.state_q !== TRACK) begin
      errors++;
      $display("FAIL load_state got %0d expected %0d", dut.state_q, TRACK);
    end
    m_gray = g;
    m_bin  = ref_g2b(g);
    m_dir  = 1'b0;
    m_ecnt = 0;
    @(negedge clk);
  endtask

  task automatic step(input logic [W-1:0] g, input bit clr);
    logic [W-1:0] d, nb, inc;
    int           pc;
    bit           serr;
    d   = g ^ m_gray;
    pc  = $countones(d);
    nb  = ref_g2b(g);
    inc = m_bin + 1'b1;
    if (pc == 1) m_dir = (nb == inc);
    serr = (pc > 1) && ERR_EN;
    if (ERR_EN) begin
      if (clr) m_ecnt = 0;
      else if (pc > 1 && m_ecnt < 15) m_ecnt++;
    end
    m_gray = g;
    m_bin  = nb;
    sb.push_back('{nb, m_dir, serr});
    Gc_input = g;
    for (int i = 0; i < S; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (Bin_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge=%0d got %b expected 0", i, Bin_valid);
      end
      if (clr && i == S - 1) clr_err = 1'b1;
    end
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checks++;
    if (Bin_valid !== 1'b1 || Bin_output !== nb) begin
      errors++;
      $display("FAIL latency_update got vld=%b bin=%0d expected vld=1 bin=%0d", Bin_valid, Bin_output, nb);
    end
    checks++;
    if (Dir_up !== m_dir) begin
      errors++;
      $display("FAIL dir_up got %b expected %b", Dir_up, m_dir);
    end
    checks++;
    if (Err_count !== 4'(m_ecnt)) begin
      errors++;
      $display("FAIL err_count got %0d expected %0d", Err_count, m_ecnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Bin_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle got %b expected 0", Bin_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(4'b0101);
  endtask

  task automatic test_count_up();
    do_reset(4'b0000);
    step(4'b0001, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0010, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset(4'b1000);
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b0);
  endtask

  task automatic test_jump();
    do_reset(4'b0000);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0011, 1'b0);
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_reset_in_flight();
    do_reset(4'b0000);
    step(4'b0001, 1'b0);
    Gc_input = 4'b0011;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Bin_output, Bin_valid, Dir_up, Step_err, Err_count} !== '0) begin
      errors++;
      $display("FAIL async_reset got bin=%0d vld=%b dir=%b serr=%b ecnt=%0d expected all 0",
               Bin_output, Bin_valid, Dir_up, Step_err, Err_count);
    end
    sb.delete();
    do_reset(4'b0011);
    step(4'b0010, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_jump();
    test_err_saturation();
    test_reset_in_flight();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
